// File: rtl/vdfsm_pkg.sv
// Shared types and constants for the vdfsm speed-control FSM.
// The optional overspeed output is enabled by defining VDFSM_OVERSPEED_EN.
package vdfsm_pkg;

  localparam int SPEED_W = 4;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } state_e;

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_ACC   = 2'b01;
  localparam logic [1:0] CMD_DEC   = 2'b10;
  localparam logic [1:0] CMD_ESTOP = 2'b11;

endpackage

// File: rtl/vdfsm_sat_step.sv
// Combinational saturating step: up clamps at max_i, down clamps at zero.
// changed_o flags whether the result differs from the current speed.
module vdfsm_sat_step
  import vdfsm_pkg::*;
(
  input  logic [SPEED_W-1:0] speed_i,
  input  logic [SPEED_W-1:0] step_i,
  input  logic [SPEED_W-1:0] max_i,
  input  logic               up_i,
  output logic [SPEED_W-1:0] next_o,
  output logic               changed_o
);

  logic [SPEED_W:0] sum;

  // One extra bit keeps the sum from wrapping before it is clamped.
  assign sum = {1'b0, speed_i} + {1'b0, step_i};

  always_comb begin
    if (up_i) begin
      next_o = (sum > {1'b0, max_i}) ? max_i : sum[SPEED_W-1:0];
    end else begin
      next_o = (speed_i >= step_i) ? (speed_i - step_i) : '0;
    end
    changed_o = (next_o != speed_i);
  end

endmodule

// File: rtl/vdfsm.sv
// Vehicle speed-control FSM: lever command raises, lowers, holds or clears speed.
// Define VDFSM_OVERSPEED_EN to add the registered overspeed output.
module vdfsm
  import vdfsm_pkg::*;
#(
  parameter logic [SPEED_W-1:0] MAX_SPEED  = 4'd12,
  parameter logic [SPEED_W-1:0] STEP       = 4'd1
`ifdef VDFSM_OVERSPEED_EN
  ,
  parameter logic [SPEED_W-1:0] WARN_LEVEL = 4'd10
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         LR,
  output logic [SPEED_W-1:0] speed
`ifdef VDFSM_OVERSPEED_EN
  ,
  output logic               overspeed
`endif
);

  state_e             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] step_next;
  logic               step_changed;

  vdfsm_sat_step u_sat_step (
    .speed_i   (speed_q),
    .step_i    (STEP),
    .max_i     (MAX_SPEED),
    .up_i      (LR == CMD_ACC),
    .next_o    (step_next),
    .changed_o (step_changed)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= STOP;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    case (LR)
      CMD_ACC: begin
        speed_d = step_next;
        state_d = step_changed ? ACCEL : CRUISE;
      end
      CMD_DEC: begin
        speed_d = step_next;
        state_d = (step_next == '0) ? STOP : DECEL;
      end
      CMD_ESTOP: begin
        speed_d = '0;
        state_d = STOP;
      end
      default: begin
        // Hold, and any unknown command, leaves speed alone.
        speed_d = speed_q;
        state_d = (speed_q == '0) ? STOP : CRUISE;
      end
    endcase
  end

`ifdef VDFSM_OVERSPEED_EN
  logic overspeed_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overspeed_q <= 1'b0;
    end else begin
      overspeed_q <= (speed_d >= WARN_LEVEL);
    end
  end
`endif

  always_comb begin
    speed = speed_q;
`ifdef VDFSM_OVERSPEED_EN
    overspeed = overspeed_q;
`endif
  end

endmodule

// File: tb/tb_vdfsm.sv
// Directed self-checking bench for vdfsm; overspeed checks run when
// VDFSM_OVERSPEED_EN is defined.
module tb_vdfsm;

  localparam logic [1:0] S_STOP   = 2'd0;
  localparam logic [1:0] S_ACCEL  = 2'd1;
  localparam logic [1:0] S_CRUISE = 2'd2;
  localparam logic [1:0] S_DECEL  = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] LR;
  logic [3:0] speed;
`ifdef VDFSM_OVERSPEED_EN
  logic       overspeed;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vdfsm dut (
    .clk   (clk),
    .reset (reset),
    .LR    (LR),
    .speed (speed)
`ifdef VDFSM_OVERSPEED_EN
    ,
    .overspeed (overspeed)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one command for one edge, then check speed and internal state.
  task automatic cyc(input string tag, input logic rst_v, input logic [1:0] lr,
                     input logic [3:0] exp_speed, input logic [1:0] exp_state);
    @(negedge clk);
    reset = rst_v;
    LR    = lr;
    @(posedge clk);
    #1;
    check({tag, "_speed"}, 8'(speed), 8'(exp_speed));
    check({tag, "_state"}, 8'(dut.state_q), 8'(exp_state));
  endtask

  initial begin
    logic [3:0] exp_v;
    reset = 1'b0;
    LR    = 2'b01;

    // Reset wins over accelerate.
    cyc("rst0", 1'b0, 2'b01, 4'd0, S_STOP);
    cyc("rst1", 1'b0, 2'b01, 4'd0, S_STOP);
    cyc("hold0", 1'b1, 2'b00, 4'd0, S_STOP);

    // Ramp up, down, hold.
    cyc("ramp1", 1'b1, 2'b01, 4'd1, S_ACCEL);
    cyc("ramp2", 1'b1, 2'b01, 4'd2, S_ACCEL);
    cyc("ramp3", 1'b1, 2'b01, 4'd3, S_ACCEL);
    cyc("ramp4", 1'b1, 2'b01, 4'd4, S_ACCEL);
    cyc("dec3",  1'b1, 2'b10, 4'd3, S_DECEL);
    cyc("dec2",  1'b1, 2'b10, 4'd2, S_DECEL);
    cyc("hold2", 1'b1, 2'b00, 4'd2, S_CRUISE);

    // Saturation: 14 accelerates from 2 reach 12 after 10, then stay.
    for (int i = 0; i < 14; i++) begin
      exp_v = (i < 10) ? 4'(3 + i) : 4'd12;
      cyc("sat_up", 1'b1, 2'b01, exp_v, (i < 10) ? S_ACCEL : S_CRUISE);
    end
    for (int i = 0; i < 11; i++) begin
      cyc("sat_dn", 1'b1, 2'b10, 4'(11 - i), S_DECEL);
    end
    cyc("dec_to0", 1'b1, 2'b10, 4'd0, S_STOP);
    cyc("dec_at0", 1'b1, 2'b10, 4'd0, S_STOP);

    // Emergency stop from 7.
    for (int i = 1; i <= 7; i++) cyc("es_ramp", 1'b1, 2'b01, 4'(i), S_ACCEL);
    cyc("estop",    1'b1, 2'b11, 4'd0, S_STOP);
    cyc("es_after", 1'b1, 2'b01, 4'd1, S_ACCEL);
    cyc("es_clr",   1'b1, 2'b11, 4'd0, S_STOP);

    // Mixed sequence from 0.
    cyc("mix1",  1'b1, 2'b01, 4'd1, S_ACCEL);
    cyc("mix2",  1'b1, 2'b01, 4'd2, S_ACCEL);
    cyc("mix3",  1'b1, 2'b01, 4'd3, S_ACCEL);
    cyc("mix4",  1'b1, 2'b01, 4'd4, S_ACCEL);
    cyc("mix5",  1'b1, 2'b10, 4'd3, S_DECEL);
    cyc("mix6",  1'b1, 2'b10, 4'd2, S_DECEL);
    cyc("mix7",  1'b1, 2'b01, 4'd3, S_ACCEL);
    cyc("mix8",  1'b1, 2'b10, 4'd2, S_DECEL);
    cyc("mix9",  1'b1, 2'b01, 4'd3, S_ACCEL);
    cyc("mix10", 1'b1, 2'b01, 4'd4, S_ACCEL);
    cyc("mix11", 1'b1, 2'b01, 4'd5, S_ACCEL);
    cyc("mix12", 1'b1, 2'b10, 4'd4, S_DECEL);
    cyc("mix13", 1'b1, 2'b01, 4'd5, S_ACCEL);
    cyc("mid_rst",  1'b0, 2'b01, 4'd0, S_STOP);
    cyc("post_rst", 1'b1, 2'b00, 4'd0, S_STOP);

    // Unknown command behaves as hold.
    cyc("x_pre",  1'b1, 2'b01, 4'd1, S_ACCEL);
    cyc("x_hold", 1'b1, 2'bxx, 4'd1, S_CRUISE);
    cyc("x_clr",  1'b1, 2'b11, 4'd0, S_STOP);

`ifdef VDFSM_OVERSPEED_EN
    for (int i = 1; i <= 9; i++) cyc("ov_ramp", 1'b1, 2'b01, 4'(i), S_ACCEL);
    check("ov_at9", 8'(overspeed), 8'd0);
    cyc("ov_10", 1'b1, 2'b01, 4'd10, S_ACCEL);
    check("ov_at10", 8'(overspeed), 8'd1);
    cyc("ov_9", 1'b1, 2'b10, 4'd9, S_DECEL);
    check("ov_back9", 8'(overspeed), 8'd0);
    for (int i = 10; i <= 12; i++) cyc("ov_up", 1'b1, 2'b01, 4'(i), S_ACCEL);
    check("ov_at12", 8'(overspeed), 8'd1);
    cyc("ov_estop", 1'b1, 2'b11, 4'd0, S_STOP);
    check("ov_estop", 8'(overspeed), 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
